// File: rtl/or_and_pkg.sv
// ---------------------------------------------------------------------------
// or_and_pkg
// Shared definitions for the OR/AND selector stimulus checker:
//   - FSM state encoding
//   - LFSR tap mask and default seed
//   - golden(a, b): reference behaviour of the OR/AND selector
//   - lfsr_advance(v): one step of the 16-bit right-shift Galois LFSR
//   - seed_fix(seed): maps an all-zero seed (LFSR lock-up) to the default
// ---------------------------------------------------------------------------
package or_and_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // Selector reference: A[7] picks OR, otherwise AND.
    function automatic logic [7:0] golden(input logic [7:0] a, input logic [7:0] b);
        return a[7] ? (a | b) : (a & b);
    endfunction

    // Galois step: shift right, fold the taps back in when a 1 falls out.
    function automatic logic [15:0] lfsr_advance(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
    endfunction

    // An all-zero state never leaves zero, so it is never used as a seed.
    function automatic logic [15:0] seed_fix(input logic [15:0] seed);
        return (seed == 16'h0000) ? DEFAULT_SEED : seed;
    endfunction

endpackage

// File: rtl/or_and_lfsr16.sv
// ---------------------------------------------------------------------------
// or_and_lfsr16
// 16-bit Galois LFSR (right shift, taps 16'hB400) producing operand pairs.
//   clk   in   1   rising-edge clock
//   rst   in   1   synchronous active-high reset; loads seed
//   load  in   1   load seed (restart the sequence)
//   step  in   1   advance one position
//   seed  in  16   start value (caller guarantees non-zero)
//   q     out 16   current LFSR state
// load has priority over step.
// ---------------------------------------------------------------------------
module or_and_lfsr16
    import or_and_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (rst || load) begin
            q <= seed;
        end else if (step) begin
            q <= lfsr_advance(q);
        end
    end

endmodule

// File: rtl/or_and_stim_checker.sv
// ---------------------------------------------------------------------------
// or_and_stim_checker
// Drives pseudo-random operand pairs into an OR/AND selector, samples its
// result after a settle time and scores it against the golden model.
//
// Parameters:
//   NUM_VECTORS    vectors per run (1..255)
//   SETTLE_CYCLES  cycles each operand pair is held before sampling (1..15)
//   LFSR_SEED      LFSR start value; 0 is replaced by DEFAULT_SEED
//   STOP_ON_FAIL   end the run at the first mismatch
//
// Ports:
//   clk             in   1   rising-edge clock
//   rst             in   1   synchronous active-high reset
//   start           in   1   run request (ignored while busy)
//   result          in   8   selector output C (combinational from A/B)
//   op_a            out  8   operand A; A[7] selects OR vs AND
//   op_b            out  8   operand B
//   busy            out  1   run in progress
//   done            out  1   run finished; held until next start or rst
//   pass            out  1   valid with done; no mismatches seen
//   vec_count       out  8   vectors checked in this run
//   fail_count      out  8   mismatches, saturating at 255
//   first_fail_idx  out  8   index of the first mismatch, 8'hFF if none
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | after reset; operands 0, waiting for start
// ST_DRIVE | operands held on A/B; settle counter runs down to 0
// ST_CHECK | compare captured result with expected value, update counters
// ST_DONE  | run over; results and last operands held, start reruns
// ---------------------------------------------------------------------------
module or_and_stim_checker
    import or_and_pkg::*;
#(
    parameter logic [7:0]  NUM_VECTORS   = 8'd255,
    parameter int          SETTLE_CYCLES = 1,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter logic        STOP_ON_FAIL  = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] result,
    output logic [7:0] op_a,
    output logic [7:0] op_b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] vec_count,
    output logic [7:0] fail_count,
    output logic [7:0] first_fail_idx
);

    localparam logic [15:0] SEED_EFF    = seed_fix(LFSR_SEED);
    localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t      state;
    logic [3:0]  settle_cnt;
    logic [7:0]  result_q;
    logic [7:0]  expect_q;

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_nxt;
    logic        lfsr_load;
    logic        lfsr_step;

    logic        start_ok;
    logic        mismatch;
    logic [7:0]  vec_next;
    logic [7:0]  fail_next;
    logic        stop_now;

    // The operand registers are loaded on the same edge the LFSR moves, so
    // they take the advanced value directly rather than lagging q by a cycle.
    assign lfsr_nxt  = lfsr_advance(lfsr_q);

    assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign mismatch  = (result_q != expect_q);
    assign vec_next  = vec_count + 8'd1;
    assign fail_next = (mismatch && (fail_count != 8'hFF)) ? fail_count + 8'd1 : fail_count;
    assign stop_now  = (vec_next == NUM_VECTORS) || (STOP_ON_FAIL && mismatch);

    assign lfsr_load = start_ok;
    assign lfsr_step = (state == ST_CHECK) && !stop_now;

    or_and_lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (lfsr_load),
        .step (lfsr_step),
        .seed (SEED_EFF),
        .q    (lfsr_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            settle_cnt     <= 4'd0;
            result_q       <= 8'd0;
            expect_q       <= 8'd0;
            op_a           <= 8'd0;
            op_b           <= 8'd0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            vec_count      <= 8'd0;
            fail_count     <= 8'd0;
            first_fail_idx <= 8'hFF;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state          <= ST_DRIVE;
                        settle_cnt     <= SETTLE_LAST;
                        op_a           <= SEED_EFF[15:8];
                        op_b           <= SEED_EFF[7:0];
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        vec_count      <= 8'd0;
                        fail_count     <= 8'd0;
                        first_fail_idx <= 8'hFF;
                    end
                end

                ST_DRIVE: begin
                    if (settle_cnt == 4'd0) begin
                        result_q <= result;
                        expect_q <= golden(op_a, op_b);
                        state    <= ST_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end

                ST_CHECK: begin
                    vec_count  <= vec_next;
                    fail_count <= fail_next;
                    // fail_count still 0 means this is the first mismatch.
                    if (mismatch && (fail_count == 8'd0)) begin
                        first_fail_idx <= vec_count;
                    end
                    if (stop_now) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (fail_next == 8'd0);
                    end else begin
                        state      <= ST_DRIVE;
                        settle_cnt <= SETTLE_LAST;
                        op_a       <= lfsr_nxt[15:8];
                        op_b       <= lfsr_nxt[7:0];
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_or_and_stim_checker.sv
module tb_or_and_stim_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_v   [3];
    logic       start_v [3];
    logic [1:0] mode_v  [3];

    logic [7:0] op_a_w [3];
    logic [7:0] op_b_w [3];
    logic [7:0] res_w  [3];
    logic [7:0] vc_w   [3];
    logic [7:0] fc_w   [3];
    logic [7:0] ffi_w  [3];
    logic       busy_w [3];
    logic       done_w [3];
    logic       pass_w [3];

    int checks   = 0;
    int failures = 0;

    // Instance configuration as seen by the model (inst2 uses seed 0 -> ACE1).
    int          cfg_n    [3] = '{4, 4, 9};
    int          cfg_s    [3] = '{1, 1, 3};
    bit          cfg_stop [3] = '{1'b0, 1'b1, 1'b0};
    logic [15:0] cfg_seed [3] = '{16'hACE1, 16'hACE1, 16'hACE1};

    function automatic logic [7:0] ref_gold(input logic [7:0] a, input logic [7:0] b);
        if (a[7]) return a | b;
        return a & b;
    endfunction

    // 0: correct, 1: stuck at 0, 2: swapped op, 3: bit0 flip when b[1:0]==0
    function automatic logic [7:0] selector(input logic [1:0] mode, input logic [7:0] a,
                                            input logic [7:0] b);
        case (mode)
            2'd0:    return ref_gold(a, b);
            2'd1:    return 8'h00;
            2'd2:    return a[7] ? (a & b) : (a | b);
            default: return (b[1:0] == 2'b00) ? (ref_gold(a, b) ^ 8'h01) : ref_gold(a, b);
        endcase
    endfunction

    assign res_w[0] = selector(mode_v[0], op_a_w[0], op_b_w[0]);
    assign res_w[1] = selector(mode_v[1], op_a_w[1], op_b_w[1]);
    assign res_w[2] = selector(mode_v[2], op_a_w[2], op_b_w[2]);

    or_and_stim_checker #(
        .NUM_VECTORS(8'd4), .SETTLE_CYCLES(1)
    ) dut0 (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .result(res_w[0]),
        .op_a(op_a_w[0]), .op_b(op_b_w[0]), .busy(busy_w[0]), .done(done_w[0]),
        .pass(pass_w[0]), .vec_count(vc_w[0]), .fail_count(fc_w[0]),
        .first_fail_idx(ffi_w[0])
    );

    or_and_stim_checker #(
        .NUM_VECTORS(8'd4), .SETTLE_CYCLES(1), .LFSR_SEED(16'hACE1), .STOP_ON_FAIL(1'b1)
    ) dut1 (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .result(res_w[1]),
        .op_a(op_a_w[1]), .op_b(op_b_w[1]), .busy(busy_w[1]), .done(done_w[1]),
        .pass(pass_w[1]), .vec_count(vc_w[1]), .fail_count(fc_w[1]),
        .first_fail_idx(ffi_w[1])
    );

    or_and_stim_checker #(
        .NUM_VECTORS(8'd9), .SETTLE_CYCLES(3), .LFSR_SEED(16'h0000), .STOP_ON_FAIL(1'b0)
    ) dut2 (
        .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .result(res_w[2]),
        .op_a(op_a_w[2]), .op_b(op_b_w[2]), .busy(busy_w[2]), .done(done_w[2]),
        .pass(pass_w[2]), .vec_count(vc_w[2]), .fail_count(fc_w[2]),
        .first_fail_idx(ffi_w[2])
    );

    // Model: per instance, a run phase (0 idle, 1 running, 2 done), the cycle
    // index inside the run, the vector list and which vectors mismatch.
    int         m_phase [3];
    int         m_t     [3];
    int         m_end   [3];
    logic [7:0] m_a     [3][256];
    logic [7:0] m_b     [3][256];
    bit         m_mis   [3][256];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_start(input int i);
        logic [15:0] s;
        bit found;
        s = cfg_seed[i];
        found = 1'b0;
        m_end[i] = cfg_n[i] - 1;
        for (int k = 0; k < cfg_n[i]; k++) begin
            m_a[i][k] = s[15:8];
            m_b[i][k] = s[7:0];
            m_mis[i][k] = (selector(mode_v[i], m_a[i][k], m_b[i][k]) != ref_gold(m_a[i][k], m_b[i][k]));
            if (cfg_stop[i] && m_mis[i][k] && !found) begin
                m_end[i] = k;
                found = 1'b1;
            end
            s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
        end
    endtask

    task automatic model_advance();
        for (int i = 0; i < 3; i++) begin
            if (rst_v[i]) begin
                m_phase[i] = 0;
            end else if (m_phase[i] != 1) begin
                if (start_v[i]) begin
                    model_start(i);
                    m_phase[i] = 1;
                    m_t[i] = 1;
                end
            end else begin
                m_t[i]++;
                if (m_t[i] == 1 + (m_end[i] + 1) * (cfg_s[i] + 1)) m_phase[i] = 2;
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            logic [7:0] ea, eb, effi;
            int upto, efc;
            logic ebusy, edone, epass;
            ea = 8'h00; eb = 8'h00; upto = 0; ebusy = 1'b0; edone = 1'b0;
            if (m_phase[i] == 1) begin
                upto = (m_t[i] - 1) / (cfg_s[i] + 1);
                ea = m_a[i][upto];
                eb = m_b[i][upto];
                ebusy = 1'b1;
            end else if (m_phase[i] == 2) begin
                ea = m_a[i][m_end[i]];
                eb = m_b[i][m_end[i]];
                upto = m_end[i] + 1;
                edone = 1'b1;
            end
            efc = 0;
            effi = 8'hFF;
            for (int k = 0; k < upto; k++) begin
                if (m_mis[i][k]) begin
                    if (efc == 0) effi = 8'(k);
                    efc++;
                end
            end
            if (efc > 255) efc = 255;
            epass = edone && (efc == 0);
            chk($sformatf("inst%0d_op_a", i), int'(op_a_w[i]), int'(ea));
            chk($sformatf("inst%0d_op_b", i), int'(op_b_w[i]), int'(eb));
            chk($sformatf("inst%0d_busy", i), int'(busy_w[i]), int'(ebusy));
            chk($sformatf("inst%0d_done", i), int'(done_w[i]), int'(edone));
            chk($sformatf("inst%0d_pass", i), int'(pass_w[i]), int'(epass));
            chk($sformatf("inst%0d_vec_count", i), int'(vc_w[i]), upto);
            chk($sformatf("inst%0d_fail_count", i), int'(fc_w[i]), efc);
            chk($sformatf("inst%0d_first_fail_idx", i), int'(ffi_w[i]), int'(effi));
        end
    endtask

    // Inputs are already driven (at a negedge); one rising edge passes.
    task automatic step();
        model_advance();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst_v[i] = 1'b1; start_v[i] = 1'b0; mode_v[i] = 2'd0;
            m_phase[i] = 0; m_t[i] = 0; m_end[i] = 0;
        end
        step();
        step();
        for (int i = 0; i < 3; i++) rst_v[i] = 1'b0;
        step();
        chk("rst_op_a", int'(op_a_w[0]), 0);
        chk("rst_first_fail_idx", int'(ffi_w[0]), 'hFF);

        // Run A: inst0 correct, inst1 swapped with stop-on-fail, inst2 S=3 correct.
        mode_v[0] = 2'd0; mode_v[1] = 2'd2; mode_v[2] = 2'd0;
        for (int i = 0; i < 3; i++) start_v[i] = 1'b1;
        step();                                      // cycle 1
        for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
        chk("vec0_op_a", int'(op_a_w[0]), 'hAC);
        chk("vec0_op_b", int'(op_b_w[0]), 'hE1);
        chk("vec0_result", int'(res_w[0]), 'hED);
        chk("vec0_swapped_result", int'(res_w[1]), 'hA0);
        step();
        step();                                      // cycle 3
        chk("vec1_op_a", int'(op_a_w[0]), 'hE2);
        chk("vec1_op_b", int'(op_b_w[0]), 'h70);
        chk("stop_done_c3", int'(done_w[1]), 1);
        chk("stop_vec_count", int'(vc_w[1]), 1);
        chk("stop_fail_count", int'(fc_w[1]), 1);
        chk("stop_first_fail", int'(ffi_w[1]), 0);
        start_v[0] = 1'b1;                           // ignored while busy
        step();                                      // cycle 4
        start_v[0] = 1'b0;
        repeat (4) step();                           // cycle 8
        chk("done_c8", int'(done_w[0]), 0);
        step();                                      // cycle 9
        chk("done_c9", int'(done_w[0]), 1);
        chk("busy_c9", int'(busy_w[0]), 0);
        chk("pass_c9", int'(pass_w[0]), 1);
        chk("fail_count_c9", int'(fc_w[0]), 0);
        chk("vec_count_c9", int'(vc_w[0]), 4);
        chk("first_fail_c9", int'(ffi_w[0]), 'hFF);
        repeat (27) step();                          // cycle 36
        chk("s3_done_c36", int'(done_w[2]), 0);
        step();                                      // cycle 37
        chk("s3_done_c37", int'(done_w[2]), 1);
        chk("s3_vec_count", int'(vc_w[2]), 9);

        // Run B: inst0 stuck at 0.
        mode_v[0] = 2'd1;
        start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        repeat (8) step();
        chk("stuck_done", int'(done_w[0]), 1);
        chk("stuck_pass", int'(pass_w[0]), 0);
        chk("stuck_fail_count", int'(fc_w[0]), 4);
        chk("stuck_first_fail", int'(ffi_w[0]), 0);

        // Reset during DRIVE of vector 2, then a fresh run.
        mode_v[0] = 2'd0;
        start_v[0] = 1'b1;
        step();                                      // cycle 1
        start_v[0] = 1'b0;
        repeat (4) step();                           // cycle 5: vector 2 DRIVE
        chk("pre_rst_vec_count", int'(vc_w[0]), 2);
        rst_v[0] = 1'b1;
        step();
        rst_v[0] = 1'b0;
        chk("abort_busy", int'(busy_w[0]), 0);
        chk("abort_op_a", int'(op_a_w[0]), 0);
        chk("abort_vec_count", int'(vc_w[0]), 0);
        chk("abort_first_fail", int'(ffi_w[0]), 'hFF);
        start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        chk("restart_op_a", int'(op_a_w[0]), 'hAC);
        chk("restart_op_b", int'(op_b_w[0]), 'hE1);
        repeat (8) step();
        chk("restart_pass", int'(pass_w[0]), 1);
        start_v[0] = 1'b1;                           // rerun from DONE
        step();
        start_v[0] = 1'b0;
        repeat (8) step();
        chk("rerun_done", int'(done_w[0]), 1);
        chk("rerun_vec_count", int'(vc_w[0]), 4);

        // Random phase: random starts (including while busy), resets, faults.
        repeat (3000) begin
            for (int i = 0; i < 3; i++) begin
                rst_v[i]   = ($urandom_range(0, 199) == 0);
                start_v[i] = ($urandom_range(0, 7) == 0);
                if (start_v[i] && (m_phase[i] != 1)) mode_v[i] = 2'($urandom_range(0, 3));
            end
            step();
        end
        for (int i = 0; i < 3; i++) begin
            rst_v[i] = 1'b0; start_v[i] = 1'b0;
        end
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
